// File: rtl/vdb_vga_pkg.sv
// -----------------------------------------------------------------------------
// vdb_vga_pkg
// Shared types and constants for the virtual-devboard VGA transmitter.
//   rgb_t        : packed {r,g,b} pixel, 8 bits per channel
//   sync_t       : front porch / sync / back porch lengths of one axis
//   fifo_word_t  : one pixel FIFO entry, {sof, rgb} (25 bits)
//   vga_state_e  : transmitter FSM state
//   in_range()   : half-open window test used for the sync regions
// -----------------------------------------------------------------------------
package vdb_vga_pkg;

    // Counter width shared by h_cnt and v_cnt; totals must stay <= 2047.
    localparam int CNT_W      = 11;
    localparam int MAX_PIXELS = 1024;
    localparam int MAX_LINES  = 768;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [CNT_W-1:0] fp;
        logic [CNT_W-1:0] sync;
        logic [CNT_W-1:0] bp;
    } sync_t;

    typedef struct packed {
        logic sof;
        rgb_t rgb;
    } fifo_word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vga_state_e;

    // True when val lies in [lo, lo+len).
    function automatic logic in_range(input logic [CNT_W-1:0] val,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] len);
        return (val >= lo) && (val < (lo + len));
    endfunction

endpackage

// File: rtl/vdb_vga_pixel_fifo.sv
// -----------------------------------------------------------------------------
// vdb_vga_pixel_fifo
// Small synchronous FIFO buffering {sof, rgb} pixel words between the upstream
// stream and the raster. The head word is visible combinationally on data_o so
// the raster logic can decide whether to consume it in the same cycle. A word
// written in cycle t becomes visible at the head in cycle t+1 (no bypass).
//
// Ports
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, empties the FIFO
//   push_i  : write request (ignored while full)
//   data_i  : write data
//   pop_i   : read request (ignored while empty)
//   data_o  : head word
//   full_o  : no free slot
//   empty_o : no stored word
// -----------------------------------------------------------------------------
module vdb_vga_pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset: stale contents are never observed because the
    // head is only used while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/vdb_vga_generator.sv
// -----------------------------------------------------------------------------
// vdb_vga_generator
// VGA transmitter: generates hsync/vsync raster timing and drives 8-bit RGB
// from an upstream ready/valid pixel stream buffered in a small FIFO. Frames
// are aligned on a start-of-frame marker carried with each pixel word.
//
// Ports
//   pixel_clk    : the only clock
//   rst_n        : asynchronous active-low reset
//   en           : enable, sampled only at a frame boundary
//   pix_valid    : upstream pixel valid
//   pix_ready    : FIFO not full
//   pix_sof      : marks the first pixel of a frame
//   pix_rgb      : {r,g,b} pixel data
//   r, g, b      : video data (black outside of popped pixels)
//   hsync, vsync : active-low sync outputs
//   de           : active video
//   frame_start  : one-cycle pulse alongside pixel (0,0)
//   underrun     : sticky flag, set when an active pixel has nothing to show
//   underrun_clr : clears underrun (a simultaneous set wins)
//
// All video outputs are registered: pins at cycle t+1 reflect the counters and
// FIFO head at cycle t.
// -----------------------------------------------------------------------------
module vdb_vga_generator
    import vdb_vga_pkg::*;
#(
    parameter int HOR_ACT    = 640,
    parameter int HOR_FP     = 16,
    parameter int HOR_SYNC   = 96,
    parameter int HOR_BP     = 48,
    parameter int VERT_ACT   = 480,
    parameter int VERT_FP    = 11,
    parameter int VERT_SYNC  = 2,
    parameter int VERT_BP    = 31,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        pix_sof,
    input  logic [23:0] pix_rgb,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start,
    output logic        underrun,
    input  logic        underrun_clr
);

    // ------------------------------------------------------------------
    // Raster geometry, all expressed at counter width.
    // ------------------------------------------------------------------
    localparam sync_t H_TIM = '{fp: CNT_W'(HOR_FP), sync: CNT_W'(HOR_SYNC), bp: CNT_W'(HOR_BP)};
    localparam sync_t V_TIM = '{fp: CNT_W'(VERT_FP), sync: CNT_W'(VERT_SYNC), bp: CNT_W'(VERT_BP)};

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_ACT_W   = CNT_W'(HOR_ACT);
    localparam logic [CNT_W-1:0] V_ACT_W   = CNT_W'(VERT_ACT);
    localparam logic [CNT_W-1:0] H_SYNC_LO = H_ACT_W + H_TIM.fp;
    localparam logic [CNT_W-1:0] V_SYNC_LO = V_ACT_W + V_TIM.fp;
    localparam logic [CNT_W-1:0] H_LAST    = H_SYNC_LO + H_TIM.sync + H_TIM.bp - CNT_ONE;
    localparam logic [CNT_W-1:0] V_LAST    = V_SYNC_LO + V_TIM.sync + V_TIM.bp - CNT_ONE;

    // ------------------------------------------------------------------
    // State, counters and output registers
    // ------------------------------------------------------------------
    vga_state_e       state_q, state_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic de_q, de_d;
    logic frame_start_q, frame_start_d;
    logic underrun_q, underrun_d;
    rgb_t rgb_q, rgb_d;

    // ------------------------------------------------------------------
    // Pixel FIFO
    // ------------------------------------------------------------------
    fifo_word_t fifo_wr;
    fifo_word_t fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;

    assign fifo_wr   = {pix_sof, pix_rgb};
    assign pix_ready = ~fifo_full;

    // The FIFO keeps accepting in IDLE so a frame can be preloaded.
    vdb_vga_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_word_t))
    ) u_fifo (
        .clk_i   (pixel_clk),
        .rst_ni  (rst_n),
        .push_i  (pix_valid),
        .data_i  (fifo_wr),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Raster decode of the current counter position
    // ------------------------------------------------------------------
    logic running;
    logic h_wrap;
    logic frame_end;
    logic h_active;
    logic v_active;
    logic active;
    logic first_pixel;
    logic h_in_sync;
    logic v_in_sync;

    assign running     = (state_q == ST_RUN);
    assign h_wrap      = (h_cnt_q == H_LAST);
    assign frame_end   = h_wrap && (v_cnt_q == V_LAST);
    assign h_active    = (h_cnt_q < H_ACT_W);
    assign v_active    = (v_cnt_q < V_ACT_W);
    assign active      = running && h_active && v_active;
    assign first_pixel = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign h_in_sync   = in_range(h_cnt_q, H_SYNC_LO, H_TIM.sync);
    assign v_in_sync   = in_range(v_cnt_q, V_SYNC_LO, V_TIM.sync);

    // ------------------------------------------------------------------
    // FSM process 1: state, counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            rgb_q         <= '0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            rgb_q         <= rgb_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state and counters
    // In IDLE the counters sit at 0, so every IDLE cycle is a frame
    // boundary and en is honoured straight away. In RUN, en only matters
    // on the cycle where both counters wrap together.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en) state_d = ST_RUN;
            ST_RUN:  if (frame_end && !en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (running) begin
            if (h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : (v_cnt_q + CNT_ONE);
            end else begin
                h_cnt_d = h_cnt_q + CNT_ONE;
                v_cnt_d = v_cnt_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs, frame alignment and underrun
    // A head word is shown only when its sof bit agrees with the raster
    // position: sof=1 exactly at pixel (0,0), sof=0 everywhere else. A
    // mismatch leaves the word in place and blanks the pixel, which either
    // waits for the marked pixel (sof=0 at frame start) or stalls an early
    // marker until the next frame. Any active pixel that cannot be shown,
    // whether the FIFO is empty or the stream is held back by alignment,
    // flags underrun. During vertical blanking unmarked words are flushed
    // one per cycle so a misaligned stream resynchronises before the next
    // frame.
    // ------------------------------------------------------------------
    always_comb begin
        fifo_pop      = 1'b0;
        hsync_d       = 1'b1;
        vsync_d       = 1'b1;
        de_d          = 1'b0;
        frame_start_d = 1'b0;
        rgb_d         = '0;
        underrun_d    = underrun_q & ~underrun_clr;

        if (running) begin
            hsync_d = ~h_in_sync;
            vsync_d = ~v_in_sync;
            if (active) begin
                de_d          = 1'b1;
                frame_start_d = first_pixel;
                if (!fifo_empty && (fifo_head.sof == first_pixel)) begin
                    fifo_pop = 1'b1;
                    rgb_d    = fifo_head.rgb;
                end else begin
                    underrun_d = 1'b1;
                end
            end else if (!v_active && !fifo_empty && !fifo_head.sof) begin
                fifo_pop = 1'b1;
            end
        end
    end

    assign r           = rgb_q.r;
    assign g           = rgb_q.g;
    assign b           = rgb_q.b;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_vdb_vga_generator.sv
// -----------------------------------------------------------------------------
// tb_vdb_vga_generator
// Self-checking bench for vdb_vga_generator with a tiny raster
// (HOR 8/2/3/2 -> 15 cycles/line, VERT 4/1/2/1 -> 8 lines, 120 cycles/frame).
// A reference model tracks the raster as a linear position within the frame
// and the FIFO as a queue; every cycle the DUT outputs are compared with it.
// Scenario checks with hand-derived constants pin the model itself.
// -----------------------------------------------------------------------------
module tb_vdb_vga_generator;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int DEPTH = 4;

    logic        pixel_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        pix_sof = 1'b0;
    logic [23:0] pix_rgb = '0;
    logic [7:0]  r, g, b;
    logic        hsync, vsync, de, frame_start, underrun;
    logic        underrun_clr = 1'b0;

    vdb_vga_generator #(
        .HOR_ACT(HA), .HOR_FP(HF), .HOR_SYNC(HS), .HOR_BP(HB),
        .VERT_ACT(VA), .VERT_FP(VF), .VERT_SYNC(VS), .VERT_BP(VB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .pixel_clk   (pixel_clk),
        .rst_n       (rst_n),
        .en          (en),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_sof     (pix_sof),
        .pix_rgb     (pix_rgb),
        .r           (r),
        .g           (g),
        .b           (b),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start),
        .underrun    (underrun),
        .underrun_clr(underrun_clr)
    );

    always #5 pixel_clk = ~pixel_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Stimulus source and reference model state
    logic [24:0] src[$];
    logic [24:0] mq[$];
    bit          m_run;
    int          m_pos;
    logic        exp_hs, exp_vs, exp_de, exp_fs, exp_ur;
    logic [23:0] exp_rgb;
    int          valid_pct = 100;
    int          clr_pct = 0;

    function automatic logic [24:0] px(input bit sof, input int v);
        logic [7:0] c;
        c = v[7:0];
        return {sof, c, c, c};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_run   = 1'b0;
        m_pos   = 0;
        exp_hs  = 1'b1;
        exp_vs  = 1'b1;
        exp_de  = 1'b0;
        exp_fs  = 1'b0;
        exp_ur  = 1'b0;
        exp_rgb = '0;
    endtask

    // One clock edge of the reference behaviour, using the inputs currently
    // driven. Position pos = h + HT*v within the frame.
    task automatic model_step();
        int  h, v;
        bit  pop, starve, accept;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pop = 0;
        starve = 0;
        accept = pix_valid && (mq.size() < DEPTH);
        exp_hs = 1'b1; exp_vs = 1'b1; exp_de = 1'b0; exp_fs = 1'b0; exp_rgb = '0;
        if (m_run) begin
            h = m_pos % HT;
            v = m_pos / HT;
            exp_hs = !(h >= HA + HF && h < HA + HF + HS);
            exp_vs = !(v >= VA + VF && v < VA + VF + VS);
            if (v < VA && h < HA) begin
                exp_de = 1'b1;
                exp_fs = (m_pos == 0);
                if (mq.size() > 0 && (mq[0][24] == (m_pos == 0))) begin
                    pop = 1;
                    exp_rgb = mq[0][23:0];
                end else begin
                    starve = 1;
                end
            end else if (v >= VA && mq.size() > 0 && !mq[0][24]) begin
                pop = 1;
            end
        end
        exp_ur = starve ? 1'b1 : (underrun_clr ? 1'b0 : exp_ur);
        if (pop) void'(mq.pop_front());
        if (accept) begin
            mq.push_back({pix_sof, pix_rgb});
            void'(src.pop_front());
        end
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos == FRAME - 1) begin
            m_pos = 0;
            if (!en) m_run = 1'b0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic compare();
        logic exp_rdy;
        exp_rdy = (mq.size() < DEPTH);
        checks++;
        if (hsync !== exp_hs || vsync !== exp_vs || de !== exp_de ||
            frame_start !== exp_fs || underrun !== exp_ur ||
            {r, g, b} !== exp_rgb || pix_ready !== exp_rdy) begin
            errors++;
            $display("FAIL outputs cycle %0d: got hs=%b vs=%b de=%b fs=%b ur=%b rgb=%h rdy=%b, expected hs=%b vs=%b de=%b fs=%b ur=%b rgb=%h rdy=%b",
                     cyc, hsync, vsync, de, frame_start, underrun, {r, g, b}, pix_ready,
                     exp_hs, exp_vs, exp_de, exp_fs, exp_ur, exp_rgb, exp_rdy);
        end
    endtask

    task automatic check_lit(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end else begin
            $display("check %s: %0d as expected", name, got);
        end
    endtask

    task automatic drive();
        pix_valid = (src.size() > 0) && ($urandom_range(99) < valid_pct);
        if (src.size() > 0) {pix_sof, pix_rgb} = src[0];
        else {pix_sof, pix_rgb} = '0;
        underrun_clr = ($urandom_range(99) < clr_pct);
    endtask

    // Model one edge, then check the DUT on the following falling edge.
    task automatic cycle();
        model_step();
        @(negedge pixel_clk);
        cyc++;
        compare();
    endtask

    task automatic do_reset(input logic en_after);
        rst_n = 1'b0;
        src.delete();
        model_reset();
        repeat (2) begin
            drive();
            cycle();
        end
        en = en_after;
        rst_n = 1'b1;
    endtask

    initial begin
        int hs_low, vs_low, de_n, nonblack, fs_n, stray, black, fs2_rgb, idle_bad;
        bit found;

        model_reset();

        // 1: no pixels supplied
        do_reset(1'b1);
        hs_low = 0; vs_low = 0; de_n = 0; nonblack = 0;
        for (int i = 0; i < 242; i++) begin
            drive(); cycle();
            if (i >= 2 && i < 122) begin
                if (!hsync) hs_low++;
                if (!vsync) vs_low++;
                if (de) de_n++;
                if (de && {r, g, b} != 24'h0) nonblack++;
            end
        end
        check_lit("s1_hsync_low_per_frame", hs_low, 24);
        check_lit("s1_vsync_low_per_frame", vs_low, 30);
        check_lit("s1_de_per_frame", de_n, 32);
        check_lit("s1_nonblack", nonblack, 0);
        check_lit("s1_underrun", int'(underrun), 1);

        // 2: continuous stream 0..31, sof on 0
        do_reset(1'b1);
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 32; k++) src.push_back(px(k == 0, k));
        de_n = 0; nonblack = 0; fs_n = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            drive(); cycle();
            if (de) begin
                if ({r, g, b} != px(0, de_n % 32)) nonblack++;
                if (frame_start) begin
                    fs_n++;
                    if ({r, g, b} != 24'h0) nonblack++;
                end
                de_n++;
            end
        end
        check_lit("s2_de_count", de_n, 128);
        check_lit("s2_wrong_pixels", nonblack, 0);
        check_lit("s2_frame_starts", fs_n, 4);
        check_lit("s2_underrun", int'(underrun), 0);

        // 3: stray unmarked pixels pushed during vertical blanking
        do_reset(1'b1);
        for (int i = 0; i < 70; i++) begin drive(); cycle(); end
        repeat (3) src.push_back(25'h0EEEEEE);
        src.push_back(25'h1555555);
        for (int k = 1; k < 32; k++) src.push_back(px(0, k));
        fs_n = 0; stray = 0; fs2_rgb = 0;
        for (int i = 0; i < 150; i++) begin
            drive(); cycle();
            if (frame_start) begin fs_n++; fs2_rgb = int'({r, g, b}); end
            if (de && {r, g, b} == 24'hEEEEEE) stray++;
        end
        check_lit("s3_frame_starts", fs_n, 1);
        check_lit("s3_first_pixel", fs2_rgb, 32'h555555);
        check_lit("s3_strays_shown", stray, 0);

        // 4: early sof at pixel 20
        do_reset(1'b1);
        for (int k = 0; k < 20; k++) src.push_back(px(k == 0, k + 1));
        for (int k = 0; k < 32; k++) src.push_back(px(k == 0, k + 100));
        black = 0; fs_n = 0; fs2_rgb = 0;
        for (int i = 0; i < 250; i++) begin
            drive(); cycle();
            if (i >= 1 && i < 121 && de && {r, g, b} == 24'h0) black++;
            if (frame_start) begin
                fs_n++;
                if (fs_n == 2) fs2_rgb = int'({r, g, b});
            end
            if (i == 121) check_lit("s4_underrun", int'(underrun), 1);
        end
        check_lit("s4_blanked", black, 12);
        check_lit("s4_next_frame_sof", fs2_rgb, 32'h646464);

        // 5: en dropped mid-frame
        do_reset(1'b1);
        valid_pct = 60;
        for (int k = 0; k < 200; k++) src.push_back(px($urandom_range(9) == 0, $urandom_range(255)));
        de_n = 0; idle_bad = 0;
        for (int i = 0; i < 250; i++) begin
            if (i == 50) en = 1'b0;
            drive(); cycle();
            if (de) de_n++;
            if (i >= 150 && (!hsync || !vsync || de)) idle_bad++;
        end
        check_lit("s5_de_before_idle", de_n, 32);
        check_lit("s5_idle_outputs", idle_bad, 0);

        // 6: reset at h=5, v=2 with the FIFO full
        do_reset(1'b1);
        valid_pct = 100;
        for (int k = 0; k < 10; k++) src.push_back(px(1, 200 + k));
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            drive(); cycle();
            if (m_run && m_pos == 35) found = 1;
        end
        check_lit("s6_reached_h5_v2", int'(found), 1);
        check_lit("s6_ready_when_full", int'(pix_ready), 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_lit("s6_rst_ready", int'(pix_ready), 1);
        check_lit("s6_rst_sync", int'({hsync, vsync, de, frame_start, underrun}), 5'b11000);
        check_lit("s6_rst_rgb", int'({r, g, b}), 0);
        compare();
        repeat (3) begin drive(); cycle(); end

        // 7: randomized traffic
        do_reset(1'b1);
        valid_pct = 70;
        clr_pct = 5;
        for (int i = 0; i < 1500; i++) begin
            while (src.size() < 4)
                src.push_back(px($urandom_range(11) == 0, $urandom_range(255)));
            if ($urandom_range(299) == 0) en = ~en;
            drive(); cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
